// File: rtl/pixel_pkg.sv
// Shared types for the pixel collector: FSM state encoding and RGB field layout.
package pixel_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int CH_W  = 8;
    localparam int R_LSB = 16;
    localparam int G_LSB = 8;
    localparam int B_LSB = 0;

endpackage

// File: rtl/pix_fifo.sv
// Per-core pixel FIFO; extra pointer bit distinguishes full from empty.
module pix_fifo #(
    parameter int PIX_W = 24,
    parameter int DEPTH = 2
) (
    input  logic             aclk,
    input  logic             aresetn,
    input  logic             clear,
    input  logic             push,
    input  logic             pop,
    input  logic [PIX_W-1:0] din,
    output logic [PIX_W-1:0] data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [PIX_W-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign data  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge aclk) begin
        if (push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/pixel_collector.sv
// Merges per-core pixel streams in strict round-robin order into one framed stream.
// Optional stall/starve counters are enabled with `define PIXEL_COLLECTOR_STATS_EN.
module pixel_collector
    import pixel_pkg::*;
#(
    parameter int NUM_CORES = 4,
    parameter int PIX_W     = 24,
    parameter int DEPTH     = 2,
    localparam int CW       = $clog2(NUM_CORES + 1)
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [CW-1:0]              active_cores,
    input  logic [31:0]                frame_pixels,
    input  logic                       flush,
    input  logic [NUM_CORES-1:0]       in_valid,
    input  logic [NUM_CORES*PIX_W-1:0] in_data,
    output logic [NUM_CORES-1:0]       in_ready,
    output logic [PIX_W-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       out_sof,
    output logic                       out_last
`ifdef PIXEL_COLLECTOR_STATS_EN
    ,
    output logic [31:0]                stall_cycles,
    output logic [31:0]                starve_cycles
`endif
);

    localparam int IW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

    state_t               state, state_nxt;
    logic [CW-1:0]        cores_q, cores_clamp;
    logic [IW-1:0]        cur;
    logic [31:0]          pix_cnt, pix_cnt_nxt;
    logic [NUM_CORES-1:0] full, empty, push, fpush, fpop;
    logic [PIX_W-1:0]     fdata  [NUM_CORES];
    logic [PIX_W-1:0]     in_pix [NUM_CORES];
    logic [PIX_W-1:0]     load_data;
    logic                 run, clear, cur_empty, load, bypass, cur_wrap, frame_last;

    assign run   = (state == RUN);
    // Flush clears in the same cycle it is seen so stale pixels never reach the output.
    assign clear = (run && flush) || (state == FLUSH);

    assign push      = in_valid & in_ready & {NUM_CORES{!flush}};
    assign cur_empty = empty[cur];
    assign load      = run && !flush && (!cur_empty || push[cur]) && (!out_valid || out_ready);
    // An empty current FIFO is bypassed so a fresh pixel reaches the output one cycle later.
    assign bypass    = load && cur_empty;
    assign load_data = cur_empty ? in_pix[cur] : fdata[cur];
    assign cur_wrap  = (CW'(cur) == cores_q - CW'(1));

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_core
        assign in_pix[g]   = in_data[g*PIX_W +: PIX_W];
        assign in_ready[g] = !full[g] && (CW'(g) < cores_q) && run;
        assign fpush[g]    = push[g] && !(bypass && (cur == IW'(g)));
        assign fpop[g]     = load && !cur_empty && (cur == IW'(g));

        pix_fifo #(.PIX_W(PIX_W), .DEPTH(DEPTH)) u_fifo (
            .aclk    (aclk),
            .aresetn (aresetn),
            .clear   (clear),
            .push    (fpush[g]),
            .pop     (fpop[g]),
            .din     (in_pix[g]),
            .data    (fdata[g]),
            .full    (full[g]),
            .empty   (empty[g])
        );
    end

    always_comb begin
        cores_clamp = active_cores;
        if (active_cores == '0)                   cores_clamp = CW'(1);
        else if (active_cores > CW'(NUM_CORES))   cores_clamp = CW'(NUM_CORES);
    end

    // frame_pixels==0 means an unbounded frame: no last marker, counter saturates.
    assign frame_last = (frame_pixels != 32'd0) && (pix_cnt == frame_pixels - 32'd1);

    always_comb begin
        pix_cnt_nxt = pix_cnt + 32'd1;
        if (frame_last)                  pix_cnt_nxt = 32'd0;
        else if (pix_cnt == 32'hFFFF_FFFF) pix_cnt_nxt = pix_cnt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = RUN;
            RUN:     if (flush) state_nxt = FLUSH;
            FLUSH:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cores_q   <= CW'(1);
            cur       <= '0;
            pix_cnt   <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_last  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE) cores_q <= cores_clamp;
            if (clear) begin
                cur       <= '0;
                pix_cnt   <= '0;
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_last  <= 1'b0;
            end else if (load) begin
                out_valid <= 1'b1;
                out_data  <= load_data;
                out_sof   <= (pix_cnt == 32'd0);
                out_last  <= frame_last;
                pix_cnt   <= pix_cnt_nxt;
                cur       <= cur_wrap ? '0 : cur + IW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef PIXEL_COLLECTOR_STATS_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else if (clear) begin
            stall_cycles  <= '0;
            starve_cycles <= '0;
        end else begin
            if (out_valid && !out_ready && stall_cycles != 32'hFFFF_FFFF)
                stall_cycles <= stall_cycles + 32'd1;
            if (run && cur_empty && !out_valid && starve_cycles != 32'hFFFF_FFFF)
                starve_cycles <= starve_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pixel_collector.sv
// Scoreboard bench for pixel_collector: directed per-core streams, monitor checks merged output.
module tb_pixel_collector;

    localparam int N = 4;
    localparam int W = 24;

    typedef struct packed {
        logic [W-1:0] d;
        logic         sof;
        logic         last;
    } exp_t;

    logic             aclk;
    logic             aresetn;
    logic [2:0]       active_cores;
    logic [31:0]      frame_pixels;
    logic             flush;
    logic [N-1:0]     in_valid;
    logic [N*W-1:0]   in_data;
    logic [N-1:0]     in_ready;
    logic [W-1:0]     out_data;
    logic             out_valid;
    logic             out_ready;
    logic             out_sof;
    logic             out_last;
`ifdef PIXEL_COLLECTOR_STATS_EN
    logic [31:0]      stall_cycles;
    logic [31:0]      starve_cycles;
`endif

    pixel_collector #(.NUM_CORES(N), .PIX_W(W), .DEPTH(2)) dut (
        .aclk         (aclk),
        .aresetn      (aresetn),
        .active_cores (active_cores),
        .frame_pixels (frame_pixels),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_sof      (out_sof),
        .out_last     (out_last)
`ifdef PIXEL_COLLECTOR_STATS_EN
        ,
        .stall_cycles (stall_cycles),
        .starve_cycles(starve_cycles)
`endif
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic [W-1:0] src [N][$];
    int           hold [N] = '{0, 0, 0, 0};
    exp_t         exp_q [$];
    logic [N-1:0] fire_prev = '0;
    int           checks = 0;
    int           errors = 0;

    // Driver: presents queue heads per core; a transfer is known at the negedge before the edge.
    always @(negedge aclk) begin
        for (int i = 0; i < N; i++)
            if (fire_prev[i] && src[i].size() > 0) void'(src[i].pop_front());
        for (int i = 0; i < N; i++) begin
            if (hold[i] > 0) begin
                hold[i]--;
                in_valid[i] = 1'b0;
            end else if (src[i].size() > 0) begin
                in_valid[i] = 1'b1;
                in_data[i*W +: W] = src[i][0];
            end else begin
                in_valid[i] = 1'b0;
            end
        end
        fire_prev = in_valid & in_ready & {N{~flush & aresetn}};
    end

    // Monitor: every accepted output is popped against the scoreboard.
    always @(negedge aclk) begin
        if (aresetn && !flush && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: got data=%06h sof=%0b last=%0b, wanted no output",
                         out_data, out_sof, out_last);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                if (out_data !== e.d || out_sof !== e.sof || out_last !== e.last) begin
                    errors++;
                    $display("FAIL out_pixel: got data=%06h sof=%0b last=%0b, wanted data=%06h sof=%0b last=%0b",
                             out_data, out_sof, out_last, e.d, e.sof, e.last);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #2;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, want);
        end
    endtask

    task automatic do_flush();
        flush = 1'b1;
        cyc(1);
        flush = 1'b0;
        cyc(3);
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            cyc(1);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: got %0d pixels outstanding, wanted 0", name, exp_q.size());
        end
        cyc(2);
    endtask

    task automatic wait_out_valid(input string name);
        int n = 0;
        while (out_valid !== 1'b1 && n < 50) begin
            cyc(1);
            n++;
        end
        check({name, "_valid_seen"}, 32'(out_valid), 32'd1);
    endtask

    task automatic clear_all();
        for (int i = 0; i < N; i++) src[i].delete();
        exp_q.delete();
    endtask

    // Fill cores 0..nc-1 with np pixels each (base | core<<16 | k) and queue the round-robin order.
    task automatic stream(input int nc, input int np, input int fp, input logic [15:0] base);
        int n = 0;
        for (int k = 0; k < np; k++)
            for (int i = 0; i < nc; i++) begin
                exp_t e;
                src[i].push_back(24'((i << 16) | base | k));
                e.d    = 24'((i << 16) | base | k);
                e.sof  = (fp == 0) ? (n == 0) : (n % fp == 0);
                e.last = (fp != 0) && (n % fp == fp - 1);
                exp_q.push_back(e);
                n++;
            end
    endtask

    initial begin
        logic [W-1:0] held;
        aresetn      = 1'b0;
        flush        = 1'b0;
        out_ready    = 1'b1;
        active_cores = 3'd4;
        frame_pixels = 32'd0;
        cyc(2);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_sof_last", 32'({out_sof, out_last}), 32'd0);
        aresetn = 1'b1;
        cyc(2);

        // 4 cores streaming continuously: one pixel per cycle, one cycle latency.
        stream(4, 3, 0, 16'h0000);
        cyc(1);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        for (int c = 0; c < 11; c++) begin
            cyc(1);
            check("thru_out_valid", 32'(out_valid), 32'd1);
        end
        wait_drain("rr4");

        // 2 cores, core 1 late: output stalls rather than skipping core 1.
        active_cores = 3'd2;
        do_flush();
        hold[1] = 10;
        stream(2, 4, 0, 16'h0100);
        cyc(6);
        check("late_in_ready0", 32'(in_ready[0]), 32'd0);
        check("late_in_ready1", 32'(in_ready[1]), 32'd1);
        check("late_in_ready32", 32'(in_ready[3:2]), 32'd0);
        check("late_stalled", 32'(out_valid), 32'd0);
        wait_drain("late");

        // Frame of 6 pixels across 3 cores.
        active_cores = 3'd3;
        frame_pixels = 32'd6;
        do_flush();
        stream(3, 4, 6, 16'h0200);
        wait_drain("frame6");

        // Zero active cores is clamped to one core.
        active_cores = 3'd0;
        frame_pixels = 32'd0;
        do_flush();
        check("clamp_in_ready", 32'(in_ready), 32'b0001);
        stream(1, 3, 0, 16'h0300);
        wait_drain("clamp");

        // Backpressure: output held stable for 5 cycles, no loss or duplication.
        active_cores = 3'd4;
        do_flush();
        out_ready = 1'b0;
        stream(4, 2, 0, 16'h0400);
        wait_out_valid("bp");
        held = out_data;
        for (int c = 0; c < 5; c++) begin
            cyc(1);
            check("bp_data_stable", 32'(out_data), 32'(held));
            check("bp_valid_held", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        wait_drain("bp");

        // Flush mid-frame with FIFOs holding data.
        frame_pixels = 32'd8;
        do_flush();
        out_ready = 1'b0;
        stream(4, 2, 8, 16'h0500);
        cyc(4);
        check("fl_pre_valid", 32'(out_valid), 32'd1);
        flush = 1'b1;
        clear_all();
        cyc(1);
        check("fl_out_valid", 32'(out_valid), 32'd0);
        flush = 1'b0;
        out_ready = 1'b1;
        cyc(3);
        stream(4, 1, 8, 16'h00AA);
        wait_drain("flush");

        // Asynchronous reset mid-stream after 5 stalled cycles.
        frame_pixels = 32'd0;
        do_flush();
        out_ready = 1'b0;
        stream(4, 2, 0, 16'h0600);
        wait_out_valid("rs");
        cyc(5);
`ifdef PIXEL_COLLECTOR_STATS_EN
        check("stall_before_rst", stall_cycles, 32'd5);
`endif
        aresetn = 1'b0;
        clear_all();
        cyc(1);
        check("rs_out_valid", 32'(out_valid), 32'd0);
        check("rs_in_ready", 32'(in_ready), 32'd0);
`ifdef PIXEL_COLLECTOR_STATS_EN
        check("stall_after_rst", stall_cycles, 32'd0);
`endif
        aresetn = 1'b1;
        out_ready = 1'b1;
        cyc(2);
        stream(4, 1, 0, 16'h00BB);
        wait_drain("reset");
        check("end_out_valid", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pixel_collector.md
PIXEL_COLLECTOR -- requirements
Module: pixel_collector

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, giving the number of ray-tracing core input channels (2..16).
REQ-002 SHALL have parameter PIX_W, default 24, giving the pixel width (R in [23:16], G in [15:8], B in [7:0]).
REQ-003 SHALL have parameter DEPTH, default 2, giving the per-core FIFO depth (power of two, at least 2).
REQ-004 SHALL have ports, in order, as listed below.
  - aclk  in  1  single clock.
  - aresetn  in  1  asynchronous, active-low reset.
  - active_cores  in  CW=$clog2(NUM_CORES+1)  number of enabled cores.
  - frame_pixels  in  32  pixels per frame.
  - flush  in  1  synchronous clear.
  - in_valid  in  NUM_CORES  per-core pixel valid.
  - in_data  in  NUM_CORES*PIX_W  per-core pixels; core i occupies [i*PIX_W +: PIX_W].
  - in_ready  out  NUM_CORES  per-core accept.
  - out_data  out  PIX_W  merged pixel stream.
  - out_valid  out  1  stream valid.
  - out_ready  in  1  downstream accept.
  - out_sof  out  1  first pixel of a frame.
  - out_last  out  1  last pixel of a frame.

Function
REQ-005 SHALL accept an input transfer on core i when in_valid[i] && in_ready[i], pushing in_data slice i into FIFO i.
REQ-006 SHALL drive in_ready[i] = !fifo_full[i] && (i < cores_q) && state==RUN; in_ready SHALL be combinational from registered state only, never from in_valid.
REQ-007 SHALL define cores_q as active_cores clamped to the range 1..NUM_CORES (0 treated as 1), latched only in state IDLE.
REQ-008 SHALL emit pixels in strict round-robin order: core 0, 1, ..., cores_q-1, then wrap to 0; pointer cur SHALL advance only when a pixel moves from FIFO cur into the output register.
REQ-009 SHALL never skip a core: while FIFO cur is empty, the output SHALL stall even if other FIFOs hold data.
REQ-010 SHALL implement a registered output stage (out_data, out_valid, out_sof, out_last) that loads from FIFO cur when FIFO cur is non-empty and (!out_valid || out_ready).
REQ-011 SHALL hold out_data, out_sof and out_last stable while out_valid && !out_ready.
REQ-012 SHALL provide latency of exactly 1 cycle from input acceptance to out_valid when FIFO cur is empty and the output register is free; back-to-back throughput SHALL be one pixel per cycle.
REQ-013 SHALL maintain a 32-bit output pixel counter pix_cnt, incremented at each output-register load; out_sof SHALL be set when pix_cnt==0, and out_last when pix_cnt==frame_pixels-1, after which pix_cnt wraps to 0.
REQ-014 SHALL, when frame_pixels==0, treat the frame as unbounded: out_sof asserts only on the first pixel after IDLE/flush, out_last never asserts, and pix_cnt saturates at its maximum.
REQ-015 SHALL implement an FSM with the following states and transitions:
  - IDLE: latch cfg; go to RUN the next cycle.
  - RUN: go to FLUSH on flush.
  - FLUSH: empty all FIFOs, clear out_valid, set cur=0 and pix_cnt=0; return to IDLE.
REQ-016 SHALL, on flush asserted together with input or output handshakes, discard those transfers: flush wins.
REQ-017 SHALL ignore changes to active_cores during RUN; they take effect only after a pass through IDLE.
REQ-018 SHALL allow a FIFO to push and pop in the same cycle when not full; push while full is impossible by REQ-006.

Reset
REQ-019 SHALL, on aresetn low, asynchronously clear state to IDLE, cur and pix_cnt to 0, all FIFO pointers to 0, and out_valid, out_sof, out_last and in_ready to 0; out_data SHALL reset to 0.
REQ-020 SHALL discard all buffered pixels on reset asserted mid-frame; the first output after release SHALL be from core 0 with out_sof=1.

Configuration
REQ-021 SHALL, with macro PIXEL_COLLECTOR_STATS_EN defined, add outputs stall_cycles (32 bits, counts cycles where out_valid && !out_ready) and starve_cycles (32 bits, counts RUN cycles where FIFO cur is empty and out_valid==0), both cleared by reset/flush and saturating.
REQ-022 SHALL, without the macro, omit both ports and counters entirely.

Structure
REQ-023 SHALL place the FSM state enum (IDLE, RUN, FLUSH) and the RGB field offset constants in the shared package pixel_pkg.
REQ-024 SHALL instantiate NUM_CORES copies of sub-module pix_fifo (parameters PIX_W and DEPTH; ports push, pop, full, empty, data, clear).

Verification
REQ-025 SHALL pass the following directed scenarios:
  - 4 cores, all valid continuously with core i sending 0x0i0000+k -> output sequence 0x000000, 0x010000, 0x020000, 0x030000, 0x000001, ... at one pixel per cycle.
  - active_cores=2, core 1 late by 10 cycles -> output stalls on core 1, core 0 FIFO fills (in_ready[0]=0 after DEPTH pixels), order preserved; in_ready[2..3] stay 0.
  - frame_pixels=6, 3 cores -> out_sof on pixels 0 and 6, out_last on pixels 5 and 11.
  - out_ready held low 5 cycles with out_valid=1 -> out_data stable; no loss or duplication after release.
  - flush mid-frame with FIFOs non-empty -> out_valid=0 within 1 cycle; next pixel is from core 0 with out_sof=1.
  - aresetn pulsed low mid-stream; with PIXEL_COLLECTOR_STATS_EN defined, 5 stall cycles -> stall_cycles=5 before reset, 0 after.
